// File: rtl/mc_control_unit.sv
// Purpose: multicycle MIPS-subset control FSM; owns PC load (pc_en/new_address) and datapath strobes.
// Latency: outputs Moore-decoded from the current state (BRANCH pc_en also uses zero/opcode); illegal_op is registered.
// Backpressure: none; the FSM advances every cycle and strobes are forced low while reset is held.
module mc_control_unit #(
    parameter int ADDR_W = 32,
    parameter int JUMP_W = 26,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic              zero,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [JUMP_W-1:0] jump_target,
    output logic              pc_en,
    output logic [ADDR_W-1:0] new_address,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [3:0]        state,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  instr_count
);

    // State codes are visible on the debug port, so they are fixed numbers.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXE    = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_ADDI_EXE = 4'd10;
    localparam logic [3:0] S_ADDI_WB  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0]       state_q, state_d;
    logic             illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    // Opcode classification shared by decode, memory split and branch sense.
    logic op_lw, op_sw, op_rtype, op_beq, op_bne, op_j, op_addi, op_legal;
    assign op_lw    = (opcode == OP_LW);
    assign op_sw    = (opcode == OP_SW);
    assign op_rtype = (opcode == OP_RTYPE);
    assign op_beq   = (opcode == OP_BEQ);
    assign op_bne   = (opcode == OP_BNE);
    assign op_j     = (opcode == OP_J);
    assign op_addi  = (opcode == OP_ADDI);
    assign op_legal = op_lw | op_sw | op_rtype | op_beq | op_bne | op_j | op_addi;

    // Jump destination: top 4 PC bits, word-aligned target, any gap bits zero.
    logic [ADDR_W-1:0] jump_addr;
    always_comb begin
        jump_addr                 = '0;
        jump_addr[JUMP_W+1:0]     = {jump_target, 2'b00};
        jump_addr[ADDR_W-1 -: 4]  = pc[ADDR_W-1 -: 4];
    end

    // Only the top nibble of pc feeds the jump address.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[ADDR_W-5:0];

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (op_lw || op_sw)         state_d = S_MEM_ADDR;
                else if (op_rtype)          state_d = S_R_EXE;
                else if (op_beq || op_bne)  state_d = S_BRANCH;
                else if (op_j)              state_d = S_JUMP;
                else if (op_addi)           state_d = S_ADDI_EXE;
                else                        state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = op_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EXE:    state_d = S_R_WB;
            S_ADDI_EXE: state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Flag an unsupported opcode one cycle after DECODE; count retirements.
    always_comb begin
        illegal_op_d  = (state_q == S_DECODE) && !op_legal;
        instr_count_d = instr_count_q;
        case (state_q)
            S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                instr_count_d = instr_count_q + CNT_W'(1);
            default: instr_count_d = instr_count_q;
        endcase
    end

    // State, illegal pulse and retired-instruction counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            illegal_op_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_op_q  <= illegal_op_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Raw Moore decode of the datapath controls from the current state.
    logic pc_en_raw, mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    always_comb begin
        pc_en_raw     = 1'b0;
        new_address   = alu_result;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b01;
                pc_en_raw    = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
            end
            S_R_EXE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_op      = 2'b01;
                new_address = alu_out;
                pc_en_raw   = (op_beq & zero) | (op_bne & ~zero);
            end
            S_JUMP: begin
                pc_en_raw   = 1'b1;
                new_address = jump_addr;
            end
            S_ADDI_WB: begin
                reg_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is async, so gate the write strobes directly with it: FETCH
    // would otherwise assert pc_en/mem_read/ir_write during reset.
    assign pc_en       = pc_en_raw     & reset;
    assign mem_read    = mem_read_raw  & reset;
    assign mem_write   = mem_write_raw & reset;
    assign ir_write    = ir_write_raw  & reset;
    assign reg_write   = reg_write_raw & reset;

    assign state       = state_q;
    assign illegal_op  = illegal_op_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level model of step sequences and counts,
// compared every cycle, plus directed literal checks from the test plan.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] alu_out = 32'd0;
    logic [25:0] jump_target = 26'd0;

    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [31:0] new_address;
    logic [1:0]  alu_src_b, alu_op;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] instr_count;

    mc_control_unit dut (
        .clk(clk), .reset(rst_n), .opcode(opcode), .zero(zero), .pc(pc),
        .alu_result(alu_result), .alu_out(alu_out), .jump_target(jump_target),
        .pc_en(pc_en), .new_address(new_address), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    // Cycles per instruction, FETCH inclusive.
    function automatic int lat(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000101, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected state code at a given step of an instruction.
    function automatic logic [3:0] exp_state(input logic [5:0] op, input int step);
        if (step < 2) return 4'(step);
        case (op)
            6'b100011: return 4'(step);                      // 2,3,4
            6'b101011: return (step == 2) ? 4'd2 : 4'd5;
            6'b000000: return 4'(4 + step);                  // 6,7
            6'b001000: return 4'(8 + step);                  // 10,11
            6'b000100, 6'b000101: return 4'd8;
            6'b000010: return 4'd9;
            default: return 4'd15;
        endcase
    endfunction

    // Expected {iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op}.
    logic [11:0] exp_ctl [16];
    initial begin
        for (int i = 0; i < 16; i++) exp_ctl[i] = 12'd0;
        exp_ctl[0]  = 12'b0101_0000_0100;
        exp_ctl[1]  = 12'b0000_0000_1100;
        exp_ctl[2]  = 12'b0000_0001_1000;
        exp_ctl[3]  = 12'b1100_0000_0000;
        exp_ctl[4]  = 12'b0000_0110_0000;
        exp_ctl[5]  = 12'b1010_0000_0000;
        exp_ctl[6]  = 12'b0000_0001_0010;
        exp_ctl[7]  = 12'b0000_1010_0000;
        exp_ctl[8]  = 12'b0000_0001_0001;
        exp_ctl[10] = 12'b0000_0001_1000;
        exp_ctl[11] = 12'b0000_0010_0000;
    end

    // Instruction-level model: step within current instruction, retired count, illegal pulse.
    int          step_m;
    logic [31:0] cnt_m;
    bit          ill_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_m <= 0;
            cnt_m  <= 32'd0;
            ill_m  <= 1'b0;
        end else begin
            ill_m <= (step_m == 1) && (lat(opcode) == 2);
            if (step_m + 1 >= lat(opcode)) begin
                step_m <= 0;
                if (lat(opcode) != 2) cnt_m <= cnt_m + 32'd1;
            end else begin
                step_m <= step_m + 1;
            end
        end
    end

    logic [11:0] dut_ctl;
    assign dut_ctl = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [3:0]  es;
        logic        epc;
        logic [31:0] ena;
        if (rst_n && chk_en) begin
            es  = exp_state(opcode, step_m);
            epc = 1'b0;
            ena = alu_result;
            if (es == 4'd0) epc = 1'b1;
            if (es == 4'd9) begin
                epc = 1'b1;
                ena = (pc & 32'hF000_0000) | ({6'd0, jump_target} << 2);
            end
            if (es == 4'd8) begin
                epc = (opcode == 6'b000100) ? zero : !zero;
                ena = alu_out;
            end
            check("state", 64'(state), 64'(es));
            check("ctl", 64'(dut_ctl), 64'(exp_ctl[es]));
            check("pc_en", 64'(pc_en), 64'(epc));
            check("new_address", 64'(new_address), 64'(ena));
            check("illegal_op", 64'(illegal_op), 64'(ill_m));
            check("instr_count", 64'(instr_count), 64'(cnt_m));
        end
    end

    // Apply one instruction; optionally pin pc_en/new_address at a given step.
    task automatic run_instr(input logic [5:0] op, input logic z, input logic [31:0] p,
                             input logic [31:0] ar, input logic [31:0] ao, input logic [25:0] jt,
                             input int probe, input logic exp_pc_en, input logic [31:0] exp_na);
        opcode = op; zero = z; pc = p; alu_result = ar; alu_out = ao; jump_target = jt;
        for (int s = 0; s < lat(op); s++) begin
            @(negedge clk);
            if (s == probe) begin
                check("probe_pc_en", 64'(pc_en), 64'(exp_pc_en));
                check("probe_new_address", 64'(new_address), 64'(exp_na));
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held low: everything idle.
        #3;
        check("rst_state", 64'(state), 64'd0);
        check("rst_strobes", 64'({pc_en, mem_read, mem_write, ir_write, reg_write}), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        check("rst_illegal", 64'(illegal_op), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // lw: first FETCH cycle loads PC+4 from alu_result.
        run_instr(6'b100011, 1'b0, 32'h1000, 32'h1004, 32'h0, 26'h0, 0, 1'b1, 32'h1004);
        check("lw_count", 64'(instr_count), 64'd1);
        run_instr(6'b101011, 1'b0, 32'h1004, 32'h2000, 32'h10, 26'h0, -1, 1'b0, 32'h0);
        run_instr(6'b000000, 1'b1, 32'h1008, 32'h2004, 32'h20, 26'h0, -1, 1'b0, 32'h0);
        run_instr(6'b001000, 1'b0, 32'h100C, 32'h3000, 32'h30, 26'h0, 3, 1'b0, 32'h3000);
        // Branches: beq/bne with both zero values.
        run_instr(6'b000100, 1'b1, 32'h1010, 32'h1014, 32'h40, 26'h0, 2, 1'b1, 32'h40);
        run_instr(6'b000100, 1'b0, 32'h1010, 32'h1014, 32'h40, 26'h0, 2, 1'b0, 32'h40);
        run_instr(6'b000101, 1'b1, 32'h1010, 32'h1014, 32'h40, 26'h0, 2, 1'b0, 32'h40);
        run_instr(6'b000101, 1'b0, 32'h1010, 32'h1014, 32'h40, 26'h0, 2, 1'b1, 32'h40);
        check("branch_count", 64'(instr_count), 64'd8);
        // Jump keeps the top PC nibble.
        run_instr(6'b000010, 1'b0, 32'hA000_0010, 32'hA000_0014, 32'h0, 26'h0000100, 2, 1'b1, 32'hA000_0400);
        check("jump_count", 64'(instr_count), 64'd9);
        // Illegal opcode: two cycles, pulse now, no retirement.
        run_instr(6'b111111, 1'b0, 32'h2000, 32'h2004, 32'h0, 26'h0, -1, 1'b0, 32'h0);
        check("illegal_pulse", 64'(illegal_op), 64'd1);
        check("illegal_count", 64'(instr_count), 64'd9);

        // Async reset in the middle of an lw (MEM_RD).
        opcode = 6'b100011; zero = 1'b0; pc = 32'h3000; alu_result = 32'h3004;
        repeat (3) @(posedge clk);
        #3;
        check("mid_state_before", 64'(state), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 64'(state), 64'd0);
        check("mid_rst_strobes", 64'({pc_en, mem_read, reg_write, ir_write, mem_write}), 64'd0);
        check("mid_rst_count", 64'(instr_count), 64'd0);
        @(posedge clk);
        #2;
        check("mid_rst_hold", 64'({state, pc_en, mem_read, reg_write}), 64'd0);
        rst_n = 1'b1;

        // Recovery: full instruction after reset counts from zero.
        run_instr(6'b000000, 1'b0, 32'h0, 32'h4, 32'h0, 26'h0, 0, 1'b1, 32'h4);
        check("post_rst_count", 64'(instr_count), 64'd1);
        run_instr(6'b100011, 1'b0, 32'h4, 32'h8, 32'h80, 26'h0, -1, 1'b0, 32'h0);
        check("final_count", 64'(instr_count), 64'd2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
